// File: rtl/scr_pkg.sv
// rtl/scr_pkg.sv - constants and helpers shared between the symbol gearbox and the scrambler stage
package scr_pkg;

   localparam int SCR_IN_W  = 64;
   localparam int SCR_SYM_W = 7;
   localparam int SCR_PAD_W = $clog2(SCR_SYM_W);

   function automatic logic [SCR_IN_W-1:0] bitrev_in(input logic [SCR_IN_W-1:0] d);
      logic [SCR_IN_W-1:0] r;
      for (int i = 0; i < SCR_IN_W; i++) begin
         r[i] = d[SCR_IN_W-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/sym7_gearbox.sv
// rtl/sym7_gearbox.sv - 64-bit word to 7-bit symbol gearbox feeding the scrambler serial_in
// Optional SYM7_BIT_REVERSE_EN: in_data[IN_W-1] becomes the first wire bit.
module sym7_gearbox
   import scr_pkg::*;
#(
   parameter int IN_W  = SCR_IN_W,
   parameter int SYM_W = SCR_SYM_W,
   parameter int BUF_W = 2*IN_W,
   parameter int PAD_W = SCR_PAD_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic [SYM_W-1:0] out_sym,
   output logic             out_valid,
   output logic             out_last,
   output logic [PAD_W-1:0] out_pad,
   input  logic             out_ready,
   output logic [CNT_W-1:0] frame_syms
);

   localparam int CW = $clog2(BUF_W+1);
   localparam logic [CW-1:0] SYM_C  = CW'(SYM_W);
   localparam logic [CW-1:0] IN_C   = CW'(IN_W);
   localparam logic [CW-1:0] ROOM_C = CW'(BUF_W-IN_W);

   logic [BUF_W-1:0] buf_q, buf_nxt;
   logic [CW-1:0]    cnt_q, cnt_nxt, used;
   logic             tail_q, new_frame_q;
   logic [CNT_W-1:0] syms_q;
   logic [IN_W-1:0]  din;
   logic             acc, emit;

`ifdef SYM7_BIT_REVERSE_EN
   assign din = bitrev_in(in_data);
`else
   assign din = in_data;
`endif

   // Admission looks only at the pre-edge count, so a same-cycle emit can never overflow buf_q.
   assign in_ready  = !rst && !tail_q && (cnt_q <= ROOM_C);
   assign acc       = in_valid && in_ready;
   assign out_valid = (cnt_q >= SYM_C) || (tail_q && (cnt_q != '0));
   assign out_last  = tail_q && (cnt_q <= SYM_C);
   assign out_pad   = out_last ? PAD_W'(SYM_C - cnt_q) : '0;
   assign emit      = out_valid && out_ready;
   assign frame_syms = syms_q;

   always_comb begin
      for (int i = 0; i < SYM_W; i++) begin
         out_sym[i] = buf_q[i] && (CW'(i) < cnt_q);
      end
   end

   always_comb begin
      used    = '0;
      buf_nxt = buf_q;
      if (emit) begin
         used    = (cnt_q < SYM_C) ? cnt_q : SYM_C;
         buf_nxt = buf_q >> SYM_W;
      end
      cnt_nxt = cnt_q - used;
      // New word lands directly above whatever survives this cycle's shift.
      if (acc) begin
         buf_nxt = buf_nxt | ({{(BUF_W-IN_W){1'b0}}, din} << cnt_nxt);
         cnt_nxt = cnt_nxt + IN_C;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q       <= '0;
         cnt_q       <= '0;
         tail_q      <= 1'b0;
         new_frame_q <= 1'b1;
         syms_q      <= '0;
      end else begin
         buf_q <= buf_nxt;
         cnt_q <= cnt_nxt;
         if (acc && in_last) begin
            tail_q <= 1'b1;
         end else if (emit && out_last) begin
            tail_q <= 1'b0;
         end
         if (emit) begin
            if (new_frame_q) begin
               syms_q <= CNT_W'(1);
            end else if (syms_q != '1) begin
               syms_q <= syms_q + CNT_W'(1);
            end
            new_frame_q <= out_last;
         end
      end
   end

endmodule

// File: tb/tb_sym7_gearbox.sv
// tb/tb_sym7_gearbox.sv - scoreboard bench for sym7_gearbox with a bit-queue reference model
module tb_sym7_gearbox;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [63:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [6:0]  out_sym;
   logic        out_valid;
   logic        out_last;
   logic [2:0]  out_pad;
   logic        out_ready = 1'b0;
   logic [15:0] frame_syms;

`ifdef SYM7_BIT_REVERSE_EN
   localparam logic [63:0] W_ONE = 64'h8000_0000_0000_0000;
`else
   localparam logic [63:0] W_ONE = 64'h1;
`endif

   sym7_gearbox dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid), .out_last(out_last),
      .out_pad(out_pad), .out_ready(out_ready), .frame_syms(frame_syms)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [6:0] sym;
      logic       last;
      logic [2:0] pad;
      int         fs;
   } exp_t;

   exp_t        expq[$];
   logic [63:0] fw[$];
   int checks = 0, errors = 0;
   bit sb_en = 1'b1;
   int prev_total = 0;
   int ready_mode = 1;
   int emits = 0, in_frame = 0, last_count = 0, frames_done = 0;
   logic [6:0] first_sym = '0;
   logic [2:0] last_pad = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Reference: flatten the frame to a bit list in wire order, then cut 7 bits at a time.
   task automatic build_frame();
      bit bits[$];
      int nb, nsym;
      foreach (fw[w]) begin
         for (int b = 0; b < 64; b++) begin
`ifdef SYM7_BIT_REVERSE_EN
            bits.push_back(fw[w][63-b]);
`else
            bits.push_back(fw[w][b]);
`endif
         end
      end
      nb   = bits.size();
      nsym = (nb + 6) / 7;
      for (int s = 0; s < nsym; s++) begin
         exp_t e;
         e.sym = '0;
         for (int k = 0; k < 7; k++) begin
            if (s*7 + k < nb) e.sym[k] = bits[s*7 + k];
         end
         e.last = (s == nsym - 1);
         e.pad  = e.last ? 3'(nsym*7 - nb) : 3'd0;
         e.fs   = (s == 0) ? prev_total : s;
         expq.push_back(e);
      end
      prev_total = nsym;
   endtask

   task automatic send(input bit push);
      if (push) build_frame();
      for (int w = 0; w < fw.size(); w++) begin
         bit done = 1'b0;
         int t = 0;
         @(negedge clk);
         in_data  = fw[w];
         in_valid = 1'b1;
         in_last  = (w == fw.size() - 1);
         while (!done) begin
            #1;
            if (rst) begin
               in_valid = 1'b0;
               in_last  = 1'b0;
               return;
            end
            if (in_ready) begin
               @(posedge clk);
               done = 1'b1;
            end else begin
               t++;
               if (t > 500) begin
                  chk("in_ready_timeout", 0, 1);
                  in_valid = 1'b0;
                  return;
               end
               @(negedge clk);
            end
         end
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_frame(input int target);
      int t = 0;
      while (frames_done < target && t < 3000) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (frames_done < target) chk("frame_timeout", frames_done, target);
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         in_frame = 0;
      end else if (out_valid && out_ready) begin
         emits++;
         if (in_frame == 0) first_sym = out_sym;
         in_frame++;
         if (out_last) begin
            last_count = in_frame;
            last_pad   = out_pad;
            in_frame   = 0;
            frames_done++;
         end
         if (sb_en) begin
            if (expq.size() == 0) begin
               chk("unexpected_symbol", 1, 0);
            end else begin
               e = expq.pop_front();
               chk("sym", out_sym, e.sym);
               chk("last", out_last, e.last);
               chk("pad", out_pad, e.pad);
               chk("frame_syms", frame_syms, e.fs);
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [6:0] held;
      bit ok;
      int t, e0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_out_pad", out_pad, 0);
      chk("rst_out_sym", out_sym, 0);
      chk("rst_frame_syms", frame_syms, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", in_ready, 1);

      ready_mode = 1;
      fw = '{W_ONE};
      send(1);
      wait_frame(1);
      chk("single_count", last_count, 10);
      chk("single_first", first_sym, 7'h01);
      chk("single_pad", last_pad, 6);
      chk("single_frame_syms", frame_syms, 10);

      fw = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      send(1);
      wait_frame(2);
      chk("two_count", last_count, 19);
      chk("two_first", first_sym, 7'h7F);
      chk("two_pad", last_pad, 5);
      chk("two_frame_syms", frame_syms, 19);

      fw.delete();
      repeat (7) fw.push_back({$urandom, $urandom});
      send(1);
      ok = 1'b1;
      t = 0;
      while (frames_done < 3 && t < 300) begin
         @(negedge clk);
         #1;
         t++;
         if (frames_done < 3 && in_ready) ok = 1'b0;
      end
      chk("tail_blocks_input", ok, 1);
      wait_frame(3);
      chk("fit_count", last_count, 64);
      chk("fit_pad", last_pad, 0);
      chk("fit_frame_syms", frame_syms, 64);

      fw = '{{$urandom, $urandom}};
      send(1);
      wait_frame(4);
      chk("after_fit_frame_syms", frame_syms, 10);

      ready_mode = 0;
      @(posedge clk);
      #3;
      fw = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
      fork
         send(1);
      join_none
      repeat (3) @(negedge clk);
      #1;
      held = out_sym;
      chk("bp_valid", out_valid, 1);
      ok = 1'b1;
      repeat (17) begin
         @(negedge clk);
         #1;
         if (out_sym !== held) ok = 1'b0;
      end
      chk("bp_sym_stable", ok, 1);
      chk("bp_in_ready_low", in_ready, 0);
      ready_mode = 1;
      wait_frame(5);
      chk("bp_count", last_count, 28);
      chk("bp_pad", last_pad, 4);

      ready_mode = 2;
      for (int f = 0; f < 10; f++) begin
         int n = $urandom_range(1, 5);
         fw.delete();
         for (int i = 0; i < n; i++) fw.push_back({$urandom, $urandom});
         send(1);
      end
      wait_frame(15);
      chk("random_queue_drained", expq.size(), 0);

      ready_mode = 1;
      sb_en = 1'b0;
      fw = '{{$urandom, $urandom}, {$urandom, $urandom}};
      e0 = emits;
      fork
         send(0);
      join_none
      t = 0;
      while (emits < e0 + 3 && t < 200) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (emits < e0 + 3) chk("reset_wait_timeout", emits - e0, 3);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_out_sym", out_sym, 0);
      chk("mid_rst_out_last", out_last, 0);
      chk("mid_rst_out_pad", out_pad, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      chk("mid_rst_frame_syms", frame_syms, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      prev_total = 0;
      sb_en = 1'b1;
      fw = '{W_ONE};
      send(1);
      wait_frame(16);
      chk("post_rst_count", last_count, 10);
      chk("post_rst_first", first_sym, 7'h01);
      chk("post_rst_frame_syms", frame_syms, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
